alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Multi-cycle, parametrised ALU: next generation of the datapath ALU.
//  Adds a valid/ready handshake and an iterative shift-add multiplier
//  (no combinational W x W multiplier). Optional restoring divider.
//  Sits between operand fetch and writeback; one operation in flight.
// PARAMETERS
//  WIDTH   8   operand width W (>=2); result width is 2W
// PORTS
//  clk         in   1     clock, all state on rising edge
//  rst         in   1     synchronous reset, active-high
//  in_valid    in   1     operands/control valid
//  in_ready    out  1     block can accept an operation
//  a, b        in   W     operands, unsigned
//  control     in   4     opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB,
//                         1100 NOR, 1101 MUL, 1110 DIV (macro only)
//  out_valid   out  1     result valid, held until out_ready
//  out_ready   in   1     consumer accepts result
//  alu_result  out  2W    result
//  zero_flag   out  1     alu_result == 0
//  err         out  1     illegal opcode or divide-by-zero
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1; out_valid=0; alu_result=0; zero_flag=0;
//   err=0. Reset mid-operation aborts it; no result is produced.
//  States: IDLE -> (accept, 1-cycle op) DONE; IDLE -> (accept MUL) MUL;
//   IDLE -> (accept DIV) DIV; MUL/DIV -> (count==W-1) DONE;
//   DONE -> (out_ready) IDLE.
//  Accept = in_valid & in_ready; a, b, control captured that edge.
//   in_ready=1 only in IDLE; in_valid while busy is ignored.
//  Latency (accept edge to out_valid high): 1 cycle for AND/OR/ADD/SUB/
//   NOR/illegal; W+1 cycles for MUL and DIV.
//  out_valid=1 only in DONE; alu_result/zero_flag/err stable while
//   out_valid=1 and out_ready=0. Completion at DONE & out_ready.
//  Width rules (results 2W bits):
//   AND/OR/NOR: {W'b0, W-bit op}.  ADD: zero-extended W+1-bit sum.
//   SUB: (a - b) mod 2^(2W) (a<b gives upper bits all ones).
//   MUL: exact unsigned product; iterate one multiplier bit per cycle.
//  Illegal opcode: alu_result=0, zero_flag=1, err=1, 1-cycle latency.
//  zero_flag and err registered with alu_result, valid with out_valid.
//  Max operands: MUL all-ones x all-ones = 2^(2W) - 2^(W+1) + 1, no loss.
// CONFIGURATION
//  ALU_DIV_EN defined: opcode 1110 = unsigned restoring divide, 1 quotient
//   bit per cycle; alu_result = {remainder[W-1:0], quotient[W-1:0]}.
//   b==0: quotient all ones, remainder = a, err=1, still W+1 latency.
//  ALU_DIV_EN undefined: no divider logic; 1110 is an illegal opcode.
// TESTING (W=8)
//  Reset, idle: in_ready=1, out_valid=0, alu_result=0, zero_flag=0.
//  ADD a=0xFF,b=0x01 -> 1 cycle later alu_result=0x0100, zero_flag=0;
//   SUB a=3,b=5 -> alu_result=0xFFFE; AND 0xF0,0x0F -> 0, zero_flag=1.
//  MUL 0xFF x 0xFF -> out_valid exactly 9 cycles after accept, 0xFE01;
//   in_valid pulses during MUL ignored, in_ready=0 throughout.
//  Backpressure: out_ready=0 for 5 cycles -> result/flags held, no
//   new accept; out_ready=1 -> IDLE, in_ready=1 next cycle.
//  rst=1 at cycle 4 of MUL -> next cycle IDLE, out_valid=0, no result.
//  Illegal 1111 -> result 0, zero_flag=1, err=1. With ALU_DIV_EN:
//   DIV 100/7 -> 0x020E; DIV 9/0 -> 0x09FF, err=1.

Source files
------------

// File: rtl/alu_mc.sv
`timescale 1ns/1ps
// alu_mc: multi-cycle unsigned ALU with valid/ready handshakes.
// One-cycle logic ops and ADD/SUB, an iterative shift-add multiplier
// (one multiplier bit per cycle) and, when the macro ALU_DIV_EN is
// defined, a restoring divider (one quotient bit per cycle).
// Results are 2*WIDTH bits; zero_flag and err are registered with them.
//
// Handshake: an operation is accepted on a rising edge where
// in_valid & in_ready (in_ready is high only in IDLE); a result is
// presented with out_valid held high, outputs stable, until the edge
// where out_ready is high, which completes it and returns to IDLE.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [3:0]           control,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   alu_result,
  output logic                 zero_flag,
  output logic                 err,
  output logic [1:0]           dbg_state_o
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1101;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIV = 4'b1110;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [RW-1:0]      result_q;
  logic               zero_q;
  logic               err_q;
  logic [CW-1:0]      cnt_q;

  // Multiplier: accumulator, left-shifting multiplicand, right-shifting multiplier
  logic [RW-1:0]      acc_q;
  logic [RW-1:0]      mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [RW-1:0]      acc_d;

  logic [WIDTH:0]     add_sum;
  logic [RW-1:0]      simple_res;
  logic               simple_err;

`ifdef ALU_DIV_EN
  // Divider: partial remainder, dividend bits shifting out / quotient in
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dsor_q;
  logic               dz_q;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;

  // One restoring step: bring in next dividend bit, subtract if it fits.
  // rem_q < divisor, so the difference always fits in WIDTH bits.
  assign div_shift = {rem_q, quo_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, dsor_q});
  assign rem_d     = div_ge ? (div_shift[WIDTH-1:0] - dsor_q) : div_shift[WIDTH-1:0];
  assign quo_d     = {quo_q[WIDTH-2:0], div_ge};
`endif

  assign add_sum = {1'b0, a} + {1'b0, b};
  assign acc_d   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Single-cycle opcode decode; anything not handled here is illegal
  always_comb begin
    simple_res = '0;
    simple_err = 1'b0;
    case (control)
      OP_AND:  simple_res = {{WIDTH{1'b0}}, a & b};
      OP_OR:   simple_res = {{WIDTH{1'b0}}, a | b};
      OP_ADD:  simple_res = {{(WIDTH-1){1'b0}}, add_sum};
      OP_SUB:  simple_res = {{WIDTH{1'b0}}, a} - {{WIDTH{1'b0}}, b};
      OP_NOR:  simple_res = {{WIDTH{1'b0}}, ~(a | b)};
      default: simple_err = 1'b1;
    endcase
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
`ifdef ALU_DIV_EN
      rem_q       <= '0;
      quo_q       <= '0;
      dsor_q      <= '0;
      dz_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            if (control == OP_MUL) begin
              acc_q    <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, a};
              mplier_q <= b;
              state_q  <= S_MUL;
            end
`ifdef ALU_DIV_EN
            else if (control == OP_DIV) begin
              rem_q   <= '0;
              quo_q   <= a;
              dsor_q  <= b;
              dz_q    <= (b == '0);
              state_q <= S_DIV;
            end
`endif
            else begin
              result_q    <= simple_res;
              zero_q      <= (simple_res == '0);
              err_q       <= simple_err;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            result_q    <= acc_d;
            zero_q      <= (acc_d == '0);
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
`ifdef ALU_DIV_EN
        S_DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            result_q    <= {rem_d, quo_d};
            zero_q      <= ({rem_d, quo_d} == '0);
            err_q       <= dz_q;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign alu_result  = result_q;
  assign zero_flag   = zero_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_mc.sv
`timescale 1ns/1ps
// Bench for alu_mc (WIDTH=8): directed corner cases then random ops,
// with a result scoreboard fed by the driver and drained by a monitor.
module tb_alu_mc;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [3:0]     control;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] alu_result;
  logic           zero_flag;
  logic           err;
  logic [1:0]     dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit prev_ov = 0;
  bit rand_ready = 0;

  // {err, zero_flag, alu_result} expected per accepted op, plus latency
  logic [2*W+1:0] exp_q[$];
  int             lat_q[$];
  int             acc_cyc_q[$];

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .control(control), .out_valid(out_valid),
    .out_ready(out_ready), .alu_result(alu_result), .zero_flag(zero_flag),
    .err(err), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [2*W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [3:0] op);
    longint unsigned xa, yb, r, mod2w, maskw;
    logic e;
    xa = x; yb = y; r = 0; e = 1'b0;
    mod2w = 64'd1 << (2*W);
    maskw = (64'd1 << W) - 1;
    case (op)
      4'b0000: r = xa & yb;
      4'b0001: r = xa | yb;
      4'b0010: r = xa + yb;
      4'b0110: r = (xa + mod2w - yb) % mod2w;
      4'b1100: r = ~(xa | yb) & maskw;
      4'b1101: r = xa * yb;
`ifdef ALU_DIV_EN
      4'b1110: begin
        if (yb == 0) begin r = (xa << W) | maskw; e = 1'b1; end
        else r = ((xa % yb) << W) | (xa / yb);
      end
`endif
      default: begin r = 0; e = 1'b1; end
    endcase
    return {e, (r == 0), r[2*W-1:0]};
  endfunction

  function automatic int model_lat(input logic [3:0] op);
`ifdef ALU_DIV_EN
    if (op == 4'b1110) return W + 1;
`endif
    return (op == 4'b1101) ? W + 1 : 1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called in the posedge+#1 phase; returns in that phase after the accept edge.
  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] yb, input logic [3:0] op);
    int t;
    t = 0;
    while (!in_ready && t < 300) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", t);
      return;
    end
    a = xa; b = yb; control = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); control = 4'($urandom);
    exp_q.push_back(model(xa, yb, op));
    lat_q.push_back(model_lat(op));
    acc_cyc_q.push_back(cyc);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(posedge clk); #1; t++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results still outstanding", exp_q.size());
      exp_q.delete(); lat_q.delete(); acc_cyc_q.delete();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out_valid: out_valid=1 result=%0h with nothing expected", alu_result);
        end else begin
          check("alu_result", alu_result, exp_q[0][2*W-1:0]);
          check("zero_flag", zero_flag, exp_q[0][2*W]);
          check("err", err, exp_q[0][2*W+1]);
          if (!prev_ov) check("latency", cyc - acc_cyc_q[0] + 1, lat_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            void'(acc_cyc_q.pop_front());
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  // Random consumer backpressure during the random phase
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] ops [8];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1101, 4'b1110, 4'b1111};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; control = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset / idle state
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", alu_result, 0);
    check("rst_zero", zero_flag, 0);
    check("rst_err", err, 0);
    check("rst_state", dbg_state, 0);

    // Single-cycle ops
    issue(8'hFF, 8'h01, 4'b0010);
    issue(8'h03, 8'h05, 4'b0110);
    issue(8'hF0, 8'h0F, 4'b0000);
    issue(8'hA5, 8'h0F, 4'b0001);
    issue(8'hA5, 8'h0F, 4'b1100);
    issue(8'h12, 8'h34, 4'b1111);
    wait_drain();

    // MUL max operands; in_valid pulses while busy must be ignored
    issue(8'hFF, 8'hFF, 4'b1101);
    in_valid = 1'b1; a = 8'h11; b = 8'h22; control = 4'b0010;
    for (int k = 0; k < W - 2; k++) begin
      check("busy_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_drain();

    // Backpressure: result held, no accept while out_ready=0
    out_ready = 1'b0;
    issue(8'h80, 8'h80, 4'b0010);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; a = 8'h01; b = 8'h01; control = 4'b0000;
      @(posedge clk); #1;
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    wait_drain();

    // Reset in the middle of a multiply aborts it
    issue(8'hAB, 8'hCD, 4'b1101);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_q.delete(); lat_q.delete(); acc_cyc_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_state", dbg_state, 0);
    repeat (W + 3) begin @(posedge clk); #1; end

    // Divide (or illegal when the divider is not built)
    issue(8'd100, 8'd7, 4'b1110);
    issue(8'd9, 8'd0, 4'b1110);
    issue(8'h00, 8'h37, 4'b1101);
    wait_drain();

    // Random ops with random consumer stalls
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      logic [3:0] op;
      op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) op = 4'($urandom);
      issue(W'($urandom), W'($urandom_range(0, 3) == 0 ? 0 : $urandom), op);
    end
    wait_drain();
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
